multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle CPU datapath; sits directly upstream of ALU_Ctrl and drives its ALUOp input plus all datapath enables and mux selects.
- Decodes the latched instruction opcode and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over 3-5 cycles.
- Supports unified-memory stalls through a ready handshake.

---
 rtl/multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Main control FSM for the multi-cycle CPU datapath. It decodes the opcode
//   held in the instruction register and sequences each instruction through
//   FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, taking 3 to 5 cycles plus
//   memory wait states. It drives the datapath enables, the mux selects and
//   ALUOp for the downstream ALU_Ctrl.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-low reset (forces BOOT)
//   op_i[5:0]      opcode from the instruction register (IR[31:26])
//   mem_ready_i    unified memory completes the current access this cycle
//   PCWrite_o      unconditional PC write enable
//   PCWriteCond_o  PC write enable qualified by ALU zero (beq)
//   IorD_o         memory address select: 0=PC, 1=ALUOut
//   MemRead_o      memory read request
//   MemWrite_o     memory write request
//   IRWrite_o      instruction register load
//   MemtoReg_o     write-back select: 0=ALUOut, 1=MDR
//   RegDst_o       destination register: 0=rt, 1=rd
//   RegWrite_o     register file write enable
//   ALUSrcA_o      0=PC, 1=rs
//   ALUSrcB_o[1:0] 00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   ALUOp_o[2:0]   0=add, 1=sub, 2=R-format, 3=slti
//   PCSource_o[1:0] 00=ALU result, 01=ALUOut, 10=jump target
//   illegal_o      one-cycle pulse: unsupported opcode seen in DECODE
//   instr_done_o   one-cycle pulse: instruction retires this cycle
//   state_o[3:0]   current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_SLTI  = 6'b001010,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALUOp_o,
    output logic [1:0] PCSource_o,
    output logic       illegal_o,
    output logic       instr_done_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_BOOT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXE    = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXE    = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_RFMT = 3'd2;
    localparam logic [2:0] ALU_SLTI = 3'd3;

    state_e state_q;
    state_e state_d;

    logic op_legal;

    always_comb begin
        op_legal = (op_i == OP_RTYPE) || (op_i == OP_ADDI) || (op_i == OP_SLTI) ||
                   (op_i == OP_BEQ)   || (op_i == OP_LW)   || (op_i == OP_SW)   ||
                   (op_i == OP_J);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                if ((op_i == OP_LW) || (op_i == OP_SW)) begin
                    state_d = S_MEM_ADDR;
                end else if (op_i == OP_RTYPE) begin
                    state_d = S_R_EXE;
                end else if ((op_i == OP_ADDI) || (op_i == OP_SLTI)) begin
                    state_d = S_I_EXE;
                end else if (op_i == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op_i == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            // IR is frozen outside FETCH, so op_i still selects lw vs sw here.
            S_MEM_ADDR: begin
                if (op_i == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (op_i == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: if (mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: if (mem_ready_i) state_d = S_FETCH;
            S_R_EXE:  state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_I_EXE:  state_d = S_I_WB;
            S_I_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode. Everything follows the state register; only the FETCH
    // write enables and the MEM_WR retire pulse look at mem_ready_i, and the
    // DECODE/I-type outputs look at the (stable) opcode.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = ALU_ADD;
        PCSource_o    = 2'b00;
        illegal_o     = 1'b0;
        instr_done_o  = 1'b0;
        state_o       = state_q;

        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                // PC+4 and IR load only commit once the fetch really returns.
                PCWrite_o = mem_ready_i;
                IRWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o    = 2'b11;
                illegal_o    = ~op_legal;
                instr_done_o = ~op_legal;
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            S_MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite_o   = 1'b1;
                IorD_o       = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_R_EXE: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALU_RFMT;
            end
            S_R_WB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            S_I_EXE: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = (op_i == OP_SLTI) ? ALU_SLTI : ALU_ADD;
            end
            S_I_WB: begin
                RegWrite_o   = 1'b1;
                // Keep the I_EXE ALUOp so ALUOut-feeding logic stays consistent.
                ALUOp_o      = (op_i == OP_SLTI) ? ALU_SLTI : ALU_ADD;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = ALU_SUB;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                instr_done_o  = 1'b1;
            end
            S_JUMP: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                instr_done_o = 1'b1;
            end
            default: begin
                // BOOT and unused codes drive everything inactive.
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Purpose:
//   Self-checking bench for multicycle_ctrl. Each instruction is expanded into
//   its expected cycle-by-cycle control vectors from the instruction's class
//   and the number of memory wait states chosen for it; the DUT outputs are
//   compared against that expansion every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] op_i;
    logic       mem_ready_i;
    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [2:0] ALUOp_o;
    logic [1:0] PCSource_o;
    logic       illegal_o, instr_done_o;
    logic [3:0] state_o;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .op_i          (op_i),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .MemtoReg_o    (MemtoReg_o),
        .RegDst_o      (RegDst_o),
        .RegWrite_o    (RegWrite_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .ALUOp_o       (ALUOp_o),
        .PCSource_o    (PCSource_o),
        .illegal_o     (illegal_o),
        .instr_done_o  (instr_done_o),
        .state_o       (state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill, done;
    } ctl_t;

    ctl_t obs;
    assign obs = {state_o, PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                  IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
                  ALUSrcB_o, ALUOp_o, PCSource_o, illegal_o, instr_done_o};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd8) || (op == 6'd10) || (op == 6'd4) ||
               (op == 6'd35) || (op == 6'd43) || (op == 6'd2);
    endfunction

    // Expected control vector for one cycle of an instruction, keyed by the
    // state code in which that cycle runs.
    function automatic ctl_t expv(input int code, input logic rdy, input logic slti);
        ctl_t e;
        e = '0;
        e.st = 4'(code);
        case (code)
            1:  begin e.mrd = 1; e.srcb = 2'b01; e.pcw = rdy; e.irw = rdy; end
            2:  begin e.srcb = 2'b11; end
            3:  begin e.srca = 1; e.srcb = 2'b10; end
            4:  begin e.mrd = 1; e.iord = 1; end
            5:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
            6:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
            7:  begin e.srca = 1; e.aluop = 3'd2; end
            8:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
            9:  begin e.srca = 1; e.srcb = 2'b10; e.aluop = slti ? 3'd3 : 3'd0; end
            10: begin e.rw = 1; e.aluop = slti ? 3'd3 : 3'd0; e.done = 1; end
            11: begin e.srca = 1; e.aluop = 3'd1; e.pcwc = 1; e.pcsrc = 2'b01; e.done = 1; end
            12: begin e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Drive one cycle's inputs just after a rising edge, check at the falling edge.
    task automatic step(input logic [5:0] op, input logic rdy, input ctl_t exp, input string tag);
        op_i        = op;
        mem_ready_i = rdy;
        @(negedge clk_i);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk_i);
        #1;
    endtask

    // One full instruction: wf fetch wait states, wm data-memory wait states.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        logic slti;
        ctl_t e;
        slti = (op == 6'd10);
        for (int i = 0; i < wf; i++) step(op, 1'b0, expv(1, 1'b0, 1'b0), "fetch_wait");
        step(op, 1'b1, expv(1, 1'b1, 1'b0), "fetch_rdy");
        if (!is_legal(op)) begin
            e = expv(2, 1'b0, 1'b0);
            e.ill  = 1'b1;
            e.done = 1'b1;
            step(op, rnd_bit(), e, "decode_illegal");
            return;
        end
        step(op, rnd_bit(), expv(2, 1'b0, 1'b0), "decode");
        case (op)
            6'd35: begin
                step(op, rnd_bit(), expv(3, 1'b0, 1'b0), "lw_addr");
                for (int i = 0; i < wm; i++) step(op, 1'b0, expv(4, 1'b0, 1'b0), "lw_rd_wait");
                step(op, 1'b1, expv(4, 1'b1, 1'b0), "lw_rd");
                step(op, rnd_bit(), expv(5, 1'b0, 1'b0), "lw_wb");
            end
            6'd43: begin
                step(op, rnd_bit(), expv(3, 1'b0, 1'b0), "sw_addr");
                for (int i = 0; i < wm; i++) step(op, 1'b0, expv(6, 1'b0, 1'b0), "sw_wr_wait");
                step(op, 1'b1, expv(6, 1'b1, 1'b0), "sw_wr");
            end
            6'd0: begin
                step(op, rnd_bit(), expv(7, 1'b0, 1'b0), "r_exe");
                step(op, rnd_bit(), expv(8, 1'b0, 1'b0), "r_wb");
            end
            6'd8, 6'd10: begin
                step(op, rnd_bit(), expv(9, 1'b0, slti), "i_exe");
                step(op, rnd_bit(), expv(10, 1'b0, slti), "i_wb");
            end
            6'd4: step(op, rnd_bit(), expv(11, 1'b0, 1'b0), "beq");
            default: step(op, rnd_bit(), expv(12, 1'b0, 1'b0), "jump");
        endcase
    endtask

    logic [5:0] legal_ops [7] = '{6'd0, 6'd8, 6'd10, 6'd4, 6'd35, 6'd43, 6'd2};

    initial begin
        logic [5:0] op;
        int         wf, wm;

        rst_i       = 1'b0;
        op_i        = 6'd0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("reset_idle", 32'(obs), 32'd0);
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("reset_ready", 32'(obs), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        step(6'd0, 1'b1, '0, "boot");

        // Directed sequences
        run_instr(6'd0, 0, 0);     // R-format
        run_instr(6'd35, 0, 2);    // lw, two read wait states
        run_instr(6'd8, 3, 0);     // addi after three fetch wait states
        run_instr(6'd10, 0, 0);    // slti
        run_instr(6'd8, 0, 0);     // addi
        run_instr(6'd4, 0, 0);     // beq
        run_instr(6'd63, 0, 0);    // illegal
        run_instr(6'd2, 0, 0);     // j
        run_instr(6'd43, 0, 1);    // sw, one write wait state

        // Asynchronous reset while sw waits in MEM_WR
        step(6'd43, 1'b1, expv(1, 1'b1, 1'b0), "ar_fetch");
        step(6'd43, 1'b1, expv(2, 1'b0, 1'b0), "ar_decode");
        step(6'd43, 1'b0, expv(3, 1'b0, 1'b0), "ar_addr");
        step(6'd43, 1'b0, expv(6, 1'b0, 1'b0), "ar_wr_wait");
        mem_ready_i = 1'b0;
        #1;
        rst_i = 1'b0;
        #1;
        check("async_reset", 32'(obs), 32'd0);
        @(negedge clk_i);
        check("reset_hold", 32'(obs), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        step(6'd43, 1'b1, '0, "boot_again");
        run_instr(6'd43, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) != 0) begin
                op = legal_ops[$urandom_range(0, 6)];
            end else begin
                op = 6'($urandom);
                for (int k = 0; k < 64 && is_legal(op); k++) op = op + 6'd1;
            end
            wf = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op, wf, wm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
